// File: rtl/vga_rect_engine.sv
// Command-list rectangle rasteriser: fetches a list pointer from BASE_ADDR, walks
// 3-word rectangle commands and streams pixels. Optional clipping: VGA_RECT_CLIP_EN.
module vga_rect_engine #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 16,
  parameter int                X_W       = 8,
  parameter int                Y_W       = 7,
  parameter int                COLOUR_W  = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                SCREEN_W  = 160,
  parameter int                SCREEN_H  = 120
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_data,
  output logic [X_W-1:0]      plot_x,
  output logic [Y_W-1:0]      plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot_valid,
  input  logic                plot_ready
);

  localparam int XS_W = ((X_W > 8) ? X_W : 8) + 1;
  localparam int YS_W = ((Y_W > 8) ? Y_W : 8) + 1;
`ifdef VGA_RECT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_PTR, S_COORD, S_COL, S_DIM, S_DRAW, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                outline_q;
  logic [7:0]          w_q, h_q, dx_q, dy_q;
  logic                fetch, ack, interior, offscreen, visible, step, last;
  logic [XS_W-1:0]     x_sum;
  logic [YS_W-1:0]     y_sum;

  // Handshakes: a memory read completes on a cycle with mem_rd && mem_ack; a pixel
  // is consumed on a cycle with plot_valid && plot_ready, and its fields hold until then.
  assign fetch = (state_q inside {S_PTR, S_COORD, S_COL, S_DIM});
  assign ack   = fetch && mem_rd && mem_ack;

  assign x_sum     = XS_W'(x_q) + XS_W'(dx_q);
  assign y_sum     = YS_W'(y_q) + YS_W'(dy_q);
  assign interior  = outline_q && (dx_q != 8'd0) && (dx_q != w_q - 8'd1)
                     && (dy_q != 8'd0) && (dy_q != h_q - 8'd1);
  assign offscreen = CLIP && ((x_sum >= XS_W'(SCREEN_W)) || (y_sum >= YS_W'(SCREEN_H)));
  assign visible   = !interior && !offscreen;
  // Hidden pixels still take one cycle each so timing does not depend on content.
  assign step      = (state_q == S_DRAW) && (!visible || plot_ready);
  assign last      = (dx_q == w_q - 8'd1) && (dy_q == h_q - 8'd1);

  assign plot_x      = x_sum[X_W-1:0];
  assign plot_y      = y_sum[Y_W-1:0];
  assign plot_colour = colour_q;
  assign plot_valid  = (state_q == S_DRAW) && visible;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PTR;
      S_PTR:   if (ack) state_d = (mem_data == '0) ? S_DONE : S_COORD;
      S_COORD: if (ack) state_d = (mem_data == '1) ? S_DONE : S_COL;
      S_COL:   if (ack) state_d = S_DIM;
      S_DIM:   if (ack) state_d = ((mem_data[7:0] == 8'd0) || (mem_data[15:8] == 8'd0))
                                  ? S_COORD : S_DRAW;
      S_DRAW:  if (step && last) state_d = S_COORD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      outline_q <= 1'b0;
      w_q       <= '0;
      h_q       <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
    end else begin
      // Request rises the cycle after entering a fetch state, falls after the ack.
      if (!fetch)       mem_rd <= 1'b0;
      else if (!mem_rd) mem_rd <= 1'b1;
      else if (mem_ack) mem_rd <= 1'b0;

      case (state_q)
        S_IDLE: if (start) mem_addr <= BASE_ADDR;
        S_PTR:  if (ack && (mem_data != '0)) mem_addr <= mem_data[ADDR_W-1:0];
        S_COORD: if (ack && (mem_data != '1)) begin
          x_q      <= mem_data[X_W-1:0];
          y_q      <= mem_data[8 +: Y_W];
          mem_addr <= mem_addr + ADDR_W'(1);
        end
        S_COL: if (ack) begin
          colour_q  <= mem_data[COLOUR_W-1:0];
          outline_q <= mem_data[15];
          mem_addr  <= mem_addr + ADDR_W'(1);
        end
        S_DIM: if (ack) begin
          w_q      <= mem_data[7:0];
          h_q      <= mem_data[15:8];
          dx_q     <= '0;
          dy_q     <= '0;
          mem_addr <= mem_addr + ADDR_W'(1);
        end
        S_DRAW: if (step) begin
          if (dx_q == w_q - 8'd1) begin
            dx_q <= '0;
            dy_q <= dy_q + 8'd1;
          end else begin
            dx_q <= dx_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_engine.sv
// Scoreboard bench for vga_rect_engine: list-walking reference model feeds an
// expected-pixel queue; a monitor pops on every accepted pixel.
module tb_vga_rect_engine;

  localparam int PIX_W = 8 + 7 + 6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        busy, done;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [5:0]  plot_colour;
  logic        plot_valid;
  logic        plot_ready;

  vga_rect_engine dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .plot_valid(plot_valid), .plot_ready(plot_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [15:0]      mem [1024];
  logic [PIX_W-1:0] exp_q[$];
  int vectors = 0, errors = 0;
  int pix_cnt = 0, done_cnt = 0, ack_cnt = 0;
  int ready_mode = 0, ack_lo = 0, ack_hi = 0, cur_dly = 0;
  bit spurious = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_mem_rd"}, 32'(mem_rd), 0);
    check({tag, "_plot_valid"}, 32'(plot_valid), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_plot_x"}, 32'(plot_x), 0);
    check({tag, "_plot_y"}, 32'(plot_y), 0);
    check({tag, "_plot_colour"}, 32'(plot_colour), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  // Reference model: walk the list in memory and enumerate visible pixels.
  task automatic build_expect(output int reads);
    logic [15:0] ptr, c, col, dim;
    int addr, w, h, xs, ys;
    bit inner;
    reads = 1;
    ptr = mem[0];
    if (ptr == 16'd0) return;
    addr = int'(ptr) % 1024;
    forever begin
      c = mem[addr];
      reads++;
      if (c == 16'hFFFF) break;
      col = mem[(addr + 1) % 1024];
      dim = mem[(addr + 2) % 1024];
      reads += 2;
      addr = (addr + 3) % 1024;
      w = int'(dim[7:0]);
      h = int'(dim[15:8]);
      for (int j = 0; j < h; j++) begin
        for (int i = 0; i < w; i++) begin
          inner = col[15] && (i > 0) && (i < w - 1) && (j > 0) && (j < h - 1);
          xs = int'(c[7:0]) + i;
          ys = int'(c[14:8]) + j;
`ifdef VGA_RECT_CLIP_EN
          if (xs >= 160 || ys >= 120) inner = 1'b1;
`endif
          if (!inner) exp_q.push_back({col[5:0], 7'(ys), 8'(xs)});
        end
      end
    end
  endtask

  // memory responder (also throws ignored acks while mem_rd is low)
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      mem_data = 16'($urandom);
      if (!resetn) wcnt = 0;
      else if (mem_rd) begin
        if (wcnt >= cur_dly) begin
          mem_ack = 1'b1;
          mem_data = mem[mem_addr];
          ack_cnt++;
          wcnt = 0;
          cur_dly = $urandom_range(ack_hi, ack_lo);
        end else wcnt++;
      end else if (spurious && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
    end
  end

  // plot_ready driver
  initial begin
    plot_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       plot_ready = 1'b1;
        1:       plot_ready = ~plot_ready;
        default: plot_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: pops the scoreboard on each accept, checks stability while stalled
  initial begin
    logic [PIX_W-1:0] got, held;
    bit stall_hold;
    stall_hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stall_hold = 1'b0;
        continue;
      end
      got = {plot_colour, plot_y, plot_x};
      if (stall_hold) begin
        check("stall_valid_held", 32'(plot_valid), 1);
        check("stall_fields_held", 32'(got), 32'(held));
      end
      if (done) done_cnt++;
      if (plot_valid && plot_ready) begin
        pix_cnt++;
        stall_hold = 1'b0;
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL pixel_extra: got 0x%0h, want none", got);
        end else begin
          check("pixel", 32'(got), 32'(exp_q.pop_front()));
        end
      end else if (plot_valid) begin
        stall_hold = 1'b1;
        held = got;
      end else begin
        stall_hold = 1'b0;
      end
    end
  end

  // driver: launch one list walk and check its completion
  task automatic run_list(input string tag, input int exp_pix);
    int reads, n;
    exp_q.delete();
    build_expect(reads);
    pix_cnt = 0;
    done_cnt = 0;
    ack_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 1);
    check({tag, "_rd_not_yet"}, 32'(mem_rd), 0);
    check({tag, "_addr_base"}, 32'(mem_addr), 0);
    @(posedge clk); #1;
    check({tag, "_rd_latency"}, 32'(mem_rd), 1);
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
      start = !done && ($urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    check({tag, "_done_timeout"}, 32'(n < 5000), 1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 0);
    check({tag, "_idle_after_done"}, 32'(busy), 0);
    check({tag, "_pixels_left"}, 32'(exp_q.size()), 0);
    check({tag, "_reads"}, 32'(ack_cnt), 32'(reads));
    check({tag, "_done_pulses"}, 32'(done_cnt), 1);
    if (exp_pix >= 0) check({tag, "_pixel_count"}, 32'(pix_cnt), 32'(exp_pix));
  endtask

  task automatic load_rect(input int a, input int x, input int y, input logic [15:0] col,
                           input int w, input int h);
    mem[a]     = {1'b0, 7'(y), 8'(x)};
    mem[a + 1] = col;
    mem[a + 2] = {8'(h), 8'(w)};
  endtask

  initial begin
    int n, ptr, a, ncmd, x;
    int reads;
    resetn = 1'b0;
    start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk) resetn = 1'b1;

    // empty list
    run_list("empty", 0);

    // 3x2 filled rectangle
    mem[0] = 16'd4;
    load_rect(4, 10, 5, 16'h002A, 3, 2);
    mem[7] = 16'hFFFF;
    run_list("fill", 6);

    // 4x4 outline
    load_rect(4, 10, 5, 16'h802A, 4, 4);
    run_list("outline", 12);

    // same with stalls, slow memory and stray acks
    ready_mode = 1; ack_lo = 3; ack_hi = 3; cur_dly = 3; spurious = 1'b1;
    run_list("stalled", 12);
    ready_mode = 0; ack_lo = 0; ack_hi = 0; cur_dly = 0;

    // zero-size command skipped, then right-edge rectangle
    clear_mem();
    mem[0] = 16'd4;
    load_rect(4, 1, 1, 16'h0011, 3, 0);
    load_rect(7, 158, 3, 16'h0015, 4, 1);
    mem[10] = 16'hFFFF;
`ifdef VGA_RECT_CLIP_EN
    run_list("edge158", 2);
`else
    run_list("edge158", 4);
`endif
    load_rect(7, 254, 3, 16'h0015, 4, 1);
`ifdef VGA_RECT_CLIP_EN
    run_list("edge254", 0);
`else
    run_list("edge254", 4);
`endif

    // reset in the middle of a rectangle
    clear_mem();
    mem[0] = 16'd40;
    load_rect(40, 30, 20, 16'h0015, 20, 5);
    mem[43] = 16'hFFFF;
    exp_q.delete();
    build_expect(reads);
    pix_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (pix_cnt < 10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_draw_reached", 32'(pix_cnt >= 10), 1);
    #2 resetn = 1'b0;
    #1 check_reset_vals("mid_reset");
    @(posedge clk); #1 check_reset_vals("mid_reset_held");
    @(negedge clk) resetn = 1'b1;
    check("mid_reset_no_done", 32'(done_cnt), 0);
    run_list("rerun", 100);

    // randomized lists
    for (int t = 0; t < 20; t++) begin
      clear_mem();
      ptr = $urandom_range(16, 900);
      mem[0] = 16'(ptr);
      ncmd = $urandom_range(0, 4);
      a = ptr;
      for (int k = 0; k < ncmd; k++) begin
        case ($urandom_range(0, 2))
          0:       x = $urandom_range(0, 255);
          1:       x = $urandom_range(150, 159);
          default: x = $urandom_range(248, 255);
        endcase
        load_rect(a, x, $urandom_range(0, 127),
                  {1'($urandom_range(0, 1)), 9'($urandom), 6'($urandom)},
                  $urandom_range(0, 7), $urandom_range(0, 6));
        a += 3;
      end
      mem[a] = 16'hFFFF;
      ready_mode = $urandom_range(0, 2);
      ack_lo = $urandom_range(0, 1);
      ack_hi = $urandom_range(1, 3);
      spurious = 1'($urandom_range(0, 1));
      run_list("random", -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
